m216_ff6: RTL and testbench
===========================

Name: m216_ff6

Overview:
- Six-bit D-type flip-flop module, modelled as one flip-chip board.
- Sits directly downstream of the 2-input NAND gate boards: gated decode and pulse terms from those boards drive its D, clock-pulse and direct set/clear inputs.
- Provides registered state (true and complement outputs) back to the gating logic.
- Runs on the single global simulation clock; flip-chip clock pulses are level inputs that are edge-qualified internally.

Parameters:
- NFF, 6, number of independent flip-flops.
- PULSE_MIN, 1, consecutive clk cycles a pulse input must stay high before it is accepted (range 1..15).
- RESET_VAL, 6'b000000, per-bit q1 value after rst.

Ports:
- clk  input  1  global simulation clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  NFF  data input per flip-flop.
- p  input  NFF  clock-pulse input per flip-flop; positive-going edge loads D.
- set_n  input  NFF  direct set, active low.
- clr_n  input  NFF  direct clear, active low.
- q1  output  NFF  "1" output (true state).
- q0  output  NFF  "0" output (complement state).

Behaviour:
- Per-bit logic is independent; all rules below apply per bit i.
- Input stage:
  - d, p, set_n and clr_n are registered once into d_r, p_r, sn_r and cn_r.
  - p_r is delayed once more into p_d, and d_r into d_d.
- Reset (asynchronous, on rst high):
  - q1 = RESET_VAL, q0 = ~RESET_VAL.
  - p_r = p_d = 1, so a pulse held high through reset release produces no edge.
  - sn_r = cn_r = 1, d_r = d_d = 0, counters = 0, hold = 0, pending = 0.
- Rise detect:
  - rise = p_r & ~p_d.
  - On rise: hold <= d_d (setup model: D sampled one clk before the pulse), cnt <= 1, pending <= 1.
- Qualification:
  - While pending and p_r = 1, cnt increments, saturating at PULSE_MIN.
  - In the cycle the run length reaches PULSE_MIN, q1 <= hold, q0 <= ~hold and pending <= 0.
  - With PULSE_MIN = 1, the commit happens on the rise cycle itself.
  - If p_r falls before PULSE_MIN is reached: pending <= 0, cnt <= 0, q unchanged (glitch rejected).
  - Only one load per pulse; a pulse held high indefinitely never reloads.
- Latency: a pulse whose first rising clk sample is edge k changes q at edge k+PULSE_MIN. Captured data is the d value sampled at edge k-1.
- Direct set/clear (level, override the pulse path, evaluated on the registered copies):
  - sn_r = 0, cn_r = 1: q1 = 1, q0 = 0.
  - cn_r = 0, sn_r = 1: q1 = 0, q0 = 1.
  - Both 0: q1 = 1 and q0 = 1 (TTL-accurate both-high state).
  - On release from both-low (either order or simultaneous), the state is q1 = 0, q0 = 1, i.e. clear wins.
  - Any direct input active cancels the pending load (pending <= 0, cnt <= 0).
  - A rise coincident with an active direct input is discarded.
- Consistency: q0 == ~q1 at all times except during both-low direct input.
- Reset mid-pulse: the pending load is discarded; after release, a new low-to-high transition is required.

Test Plan:
- Reset then load: rst high, RESET_VAL = 6'b101010 -> q1 = 101010, q0 = 010101. Release rst; d = 6'b000111 held; p = 6'b000111 pulse for 1 cycle -> q1 = 101111 exactly 1 clk after the pulse is first sampled (PULSE_MIN = 1); bits 3..5 unchanged.
- Setup model: d[0] 0->1 in the same cycle p[0] rises -> q1[0] loads 0 (old value). Repeat with d[0] = 1 one cycle earlier -> q1[0] = 1.
- Glitch filter: PULSE_MIN = 3. p[2] high for 2 cycles -> q1[2] unchanged. p[2] high for 3 cycles -> q1[2] = d value, commit at edge k+3. p[2] held high for 20 cycles while d toggles -> exactly one load.
- Direct inputs: clr_n[4] = 0 -> q1[4] = 0, q0[4] = 1 after 1 input-register cycle. set_n[4] = clr_n[4] = 0 -> q1[4] = q0[4] = 1. Release both simultaneously -> q1[4] = 0, q0[4] = 1. Pulse on p[4] while clr_n[4] = 0 -> ignored.
- Reset mid-operation: PULSE_MIN = 4. Assert rst on the 2nd cycle of a p[1] pulse -> q1[1] = RESET_VAL[1]. Keep p[1] high across release -> no load until p[1] goes low then high again.
- Independence: random p/d/set_n/clr_n on all 6 bits for 10k cycles -> bench scoreboard matches q1/q0 per the rules above; q0 == ~q1 whenever set_n | clr_n is all-ones.

Source files
------------

// File: rtl/m216_ff6.sv
// m216_ff6 - six-bit D-type flip-flop board.
//
// Each bit is an independent edge-qualified D flip-flop. The pulse input p
// is a level signal; a low-to-high transition on its registered copy arms a
// load, and the load commits once the pulse has stayed high for PULSE_MIN
// clk cycles. Shorter pulses are rejected as glitches. The D value that is
// loaded is the one sampled one clk before the pulse was first seen, which
// models the setup requirement of the original board.
//
// Direct set/clear are level inputs. They act on their registered copies
// and override the pulse path.
//
// Ports:
//   clk    in   global simulation clock, rising edge
//   rst    in   asynchronous active-high reset
//   d      in   [NFF] data input per flip-flop
//   p      in   [NFF] clock-pulse input per flip-flop
//   set_n  in   [NFF] direct set, active low
//   clr_n  in   [NFF] direct clear, active low
//   q1     out  [NFF] true output
//   q0     out  [NFF] complement output
//
// Per-bit load sequencing:
//   state       | meaning
//   idle        | pend_q = 0, no load in progress
//   qualifying  | pend_q = 1, rise seen, counting pulse length in cnt_q
//   both_low    | both_q = 1, set and clear were both asserted; forced to
//               | the clear state until every direct input is released
module m216_ff6 #(
    parameter int             NFF       = 6,
    parameter int             PULSE_MIN = 1,
    parameter logic [NFF-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NFF-1:0] d,
    input  logic [NFF-1:0] p,
    input  logic [NFF-1:0] set_n,
    input  logic [NFF-1:0] clr_n,
    output logic [NFF-1:0] q1,
    output logic [NFF-1:0] q0
);

    localparam logic [3:0] PMIN = 4'(PULSE_MIN);

    logic [NFF-1:0] d_r_q,   d_r_d;
    logic [NFF-1:0] d_dly_q, d_dly_d;
    logic [NFF-1:0] p_r_q,   p_r_d;
    logic [NFF-1:0] p_dly_q, p_dly_d;
    logic [NFF-1:0] sn_r_q,  sn_r_d;
    logic [NFF-1:0] cn_r_q,  cn_r_d;
    logic [NFF-1:0] hold_q,  hold_d;
    logic [NFF-1:0] pend_q,  pend_d;
    logic [NFF-1:0] both_q,  both_d;
    logic [NFF-1:0] q1_q,    q1_d;
    logic [NFF-1:0] q0_q,    q0_d;
    logic [3:0]     cnt_q [NFF];
    logic [3:0]     cnt_d [NFF];
    logic [NFF-1:0] rise;

    assign rise = p_r_q & ~p_dly_q;

    // State register. The pulse pipeline resets high so a pulse held across
    // reset release does not look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r_q   <= '0;
            d_dly_q <= '0;
            p_r_q   <= '1;
            p_dly_q <= '1;
            sn_r_q  <= '1;
            cn_r_q  <= '1;
            hold_q  <= '0;
            pend_q  <= '0;
            both_q  <= '0;
            q1_q    <= RESET_VAL;
            q0_q    <= ~RESET_VAL;
            for (int i = 0; i < NFF; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            d_r_q   <= d_r_d;
            d_dly_q <= d_dly_d;
            p_r_q   <= p_r_d;
            p_dly_q <= p_dly_d;
            sn_r_q  <= sn_r_d;
            cn_r_q  <= cn_r_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            both_q  <= both_d;
            q1_q    <= q1_d;
            q0_q    <= q0_d;
            for (int i = 0; i < NFF; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        d_r_d   = d;
        d_dly_d = d_r_q;
        p_r_d   = p;
        p_dly_d = p_r_q;
        sn_r_d  = set_n;
        cn_r_d  = clr_n;
        hold_d  = hold_q;
        pend_d  = pend_q;
        both_d  = both_q;
        q1_d    = q1_q;
        q0_d    = q0_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NFF; i++) begin
            if (!sn_r_q[i] || !cn_r_q[i]) begin
                // Direct inputs cancel any load in progress and swallow a
                // coincident rise.
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                if (!sn_r_q[i] && !cn_r_q[i]) begin
                    q1_d[i]   = 1'b1;
                    q0_d[i]   = 1'b1;
                    both_d[i] = 1'b1;
                end else if (both_q[i] || !cn_r_q[i]) begin
                    // Leaving both-low in either order lands in the clear state.
                    q1_d[i] = 1'b0;
                    q0_d[i] = 1'b1;
                end else begin
                    q1_d[i] = 1'b1;
                    q0_d[i] = 1'b0;
                end
            end else if (both_q[i]) begin
                both_d[i] = 1'b0;
                q1_d[i]   = 1'b0;
                q0_d[i]   = 1'b1;
            end else if (rise[i]) begin
                hold_d[i] = d_dly_q[i];
                cnt_d[i]  = 4'd1;
                pend_d[i] = 1'b1;
                if (PMIN <= 4'd1) begin
                    q1_d[i]   = d_dly_q[i];
                    q0_d[i]   = ~d_dly_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (pend_q[i]) begin
                if (p_r_q[i]) begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                    if (cnt_q[i] + 4'd1 >= PMIN) begin
                        q1_d[i]   = hold_q[i];
                        q0_d[i]   = ~hold_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    pend_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end
            end
        end
    end

    // Outputs.
    always_comb begin
        q1 = q1_q;
        q0 = q0_q;
    end

endmodule

// File: tb/tb_m216_ff6.sv
module tb_m216_ff6;

    localparam logic [5:0] RV = 6'b101010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] d = '0, p = '0, set_n = '1, clr_n = '1;
    logic [5:0] q1a, q0a, q1b, q0b, q1c, q0c;

    always #5 clk = ~clk;

    m216_ff6 #(.NFF(6), .PULSE_MIN(1), .RESET_VAL(RV)) u_p1 (
        .clk(clk), .rst(rst), .d(d), .p(p), .set_n(set_n), .clr_n(clr_n),
        .q1(q1a), .q0(q0a));
    m216_ff6 #(.NFF(6), .PULSE_MIN(3), .RESET_VAL(RV)) u_p3 (
        .clk(clk), .rst(rst), .d(d), .p(p), .set_n(set_n), .clr_n(clr_n),
        .q1(q1b), .q0(q0b));
    m216_ff6 #(.NFF(6), .PULSE_MIN(4), .RESET_VAL(RV)) u_p4 (
        .clk(clk), .rst(rst), .d(d), .p(p), .set_n(set_n), .clr_n(clr_n),
        .q1(q1c), .q0(q0c));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, written over the history of input samples:
    // run    = length of the current high run of p samples
    // valid  = that run began with a genuine low->high and has not been
    //          disturbed by reset or a direct input
    // cap    = d sampled one clk before the run began
    int         pmin [3] = '{1, 3, 4};
    int         run  [6];
    bit         valid[6];
    bit         bl   [6];
    bit         cap  [3][6];
    logic [5:0] mq1  [3];
    logic [5:0] mq0  [3];
    logic [5:0] s_n, c_n, p_n, d_n, d_nm1;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            run[i]   = 1;
            valid[i] = 1'b0;
            bl[i]    = 1'b0;
        end
        s_n = '1; c_n = '1; p_n = '1; d_n = '0; d_nm1 = '0;
        for (int j = 0; j < 3; j++) begin
            mq1[j] = RV;
            mq0[j] = ~RV;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 6; i++) begin
            if (!s_n[i] || !c_n[i]) begin
                valid[i] = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (!s_n[i] && !c_n[i]) begin mq1[j][i] = 1'b1; mq0[j][i] = 1'b1; end
                    else if (bl[i] || !c_n[i]) begin mq1[j][i] = 1'b0; mq0[j][i] = 1'b1; end
                    else begin mq1[j][i] = 1'b1; mq0[j][i] = 1'b0; end
                end
                if (!s_n[i] && !c_n[i]) bl[i] = 1'b1;
            end else if (bl[i]) begin
                bl[i]    = 1'b0;
                valid[i] = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    mq1[j][i] = 1'b0;
                    mq0[j][i] = 1'b1;
                end
            end else if (valid[i] && p_n[i]) begin
                for (int j = 0; j < 3; j++) begin
                    if (run[i] == 1) cap[j][i] = d_nm1[i];
                    if (run[i] == pmin[j]) begin
                        mq1[j][i] = cap[j][i];
                        mq0[j][i] = ~cap[j][i];
                    end
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (p[i]) begin
                if (run[i] == 0) begin run[i] = 1; valid[i] = 1'b1; end
                else if (run[i] < 1000) run[i]++;
            end else begin
                run[i]   = 0;
                valid[i] = 1'b0;
            end
        end
        d_nm1 = d_n;
        d_n   = d;
        p_n   = p;
        s_n   = set_n;
        c_n   = clr_n;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_edge();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("p1_q1", q1a, mq1[0]);
        chk("p1_q0", q0a, mq0[0]);
        chk("p3_q1", q1b, mq1[1]);
        chk("p3_q0", q0b, mq0[1]);
        chk("p4_q1", q1c, mq1[2]);
        chk("p4_q0", q0c, mq0[2]);
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_q1", q1a, 6'b101010);
        chk("rst_q0", q0a, 6'b010101);
        cycn(2);
        rst = 1'b0;

        // Basic load with PULSE_MIN = 1
        d = 6'b000111;
        cycn(2);
        p = 6'b000111;
        cyc();
        chk("load_latency", q1a, 6'b101010);
        p = '0;
        cyc();
        chk("load_p1", q1a, 6'b101111);
        chk("load_p3_glitch", q1b, 6'b101010);
        cycn(2);

        // Setup model: D changing with the pulse gives the old value
        d = 6'b000110;
        cycn(2);
        d = 6'b000111;
        p = 6'b000001;
        cyc();
        p = '0;
        cyc();
        chk("setup_old", q1a, 6'b101110);
        cycn(2);
        p = 6'b000001;
        cyc();
        p = '0;
        cyc();
        chk("setup_early", q1a, 6'b101111);
        cycn(2);

        // Glitch filter, PULSE_MIN = 3, bit 2
        p = 6'b000100;
        cycn(2);
        p = '0;
        cycn(3);
        chk("glitch_2cyc", q1b, 6'b101010);
        p = 6'b000100;
        cycn(3);
        chk("qual_k2", q1b, 6'b101010);
        p = '0;
        cyc();
        chk("qual_k3", q1b, 6'b101110);
        d = 6'b000011;
        cycn(2);
        p = 6'b000100;
        for (int k = 0; k < 20; k++) begin
            cyc();
            d[2] = ~d[2];
        end
        p = '0;
        cyc();
        chk("one_load", q1b, 6'b101010);

        // Direct set/clear on bit 4
        set_n = 6'b101111;
        cycn(2);
        chk("set_q1", {5'b0, q1a[4]}, 6'd1);
        chk("set_q0", {5'b0, q0a[4]}, 6'd0);
        set_n = '1;
        clr_n = 6'b101111;
        cycn(2);
        chk("clr_q1", {5'b0, q1a[4]}, 6'd0);
        chk("clr_q0", {5'b0, q0a[4]}, 6'd1);
        set_n = 6'b101111;
        cycn(2);
        chk("both_q1", {5'b0, q1a[4]}, 6'd1);
        chk("both_q0", {5'b0, q0a[4]}, 6'd1);
        set_n = '1;
        clr_n = '1;
        cycn(2);
        chk("rel_q1", {5'b0, q1a[4]}, 6'd0);
        chk("rel_q0", {5'b0, q0a[4]}, 6'd1);
        clr_n = 6'b101111;
        d = 6'b010011;
        cycn(2);
        p = 6'b010000;
        cyc();
        p = '0;
        cycn(2);
        clr_n = '1;
        cycn(2);
        chk("clr_blocks_load", {5'b0, q1a[4]}, 6'd0);

        // Reset in the middle of a pulse, PULSE_MIN = 4, bit 1
        d = 6'b010000;
        cycn(2);
        p = 6'b000010;
        cycn(2);
        rst = 1'b1;
        #1;
        chk("midrst_q1", q1c, RV);
        cycn(2);
        rst = 1'b0;
        cycn(8);
        chk("held_no_load", q1c, 6'b101010);
        p = '0;
        cycn(2);
        p = 6'b000010;
        cycn(5);
        p = '0;
        cyc();
        chk("reload", q1c, 6'b101000);

        // Random traffic on all bits
        for (int k = 0; k < 10000; k++) begin
            p     = p ^ (6'($urandom) & 6'($urandom));
            d     = 6'($urandom);
            set_n = ~(6'($urandom) & 6'($urandom) & 6'($urandom) & 6'($urandom));
            clr_n = ~(6'($urandom) & 6'($urandom) & 6'($urandom) & 6'($urandom));
            if ($urandom_range(999) == 0) begin
                rst = 1'b1;
                #1;
                cyc();
                rst = 1'b0;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
